// File: rtl/triangle_setup.sv
// triangle_setup: y-sorts three vertices, derives edge slopes with a serial divider and
// commits flat-bottom / flat-top rasterizer setup in signed fixed point.
module triangle_setup #(
  parameter int SLOPE_RES = 28,
  parameter int FRACT_RES = 16
) (
  input  logic                        pixel_clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [11:0]          x0,
  input  logic signed [11:0]          y0,
  input  logic signed [11:0]          x1,
  input  logic signed [11:0]          y1,
  input  logic signed [11:0]          x2,
  input  logic signed [11:0]          y2,
  input  logic [23:0]                 color,
  output logic                        busy,
  output logic                        out_valid,
  output logic signed [SLOPE_RES-1:0] fb_x_p1,
  output logic signed [SLOPE_RES-1:0] fb_y_p1,
  output logic signed [SLOPE_RES-1:0] fb_x_p2,
  output logic signed [SLOPE_RES-1:0] fb_y_p2,
  output logic signed [SLOPE_RES-1:0] fb_x_p3,
  output logic signed [SLOPE_RES-1:0] fb_y_p3,
  output logic signed [SLOPE_RES-1:0] fb_dx_p1p2,
  output logic signed [SLOPE_RES-1:0] fb_dx_p1p3,
  output logic signed [SLOPE_RES-1:0] ft_x_p1,
  output logic signed [SLOPE_RES-1:0] ft_y_p1,
  output logic signed [SLOPE_RES-1:0] ft_x_p2,
  output logic signed [SLOPE_RES-1:0] ft_y_p2,
  output logic signed [SLOPE_RES-1:0] ft_x_p3,
  output logic signed [SLOPE_RES-1:0] ft_y_p3,
  output logic signed [SLOPE_RES-1:0] ft_dx_p1p2,
  output logic signed [SLOPE_RES-1:0] ft_dx_p1p3,
  output logic [23:0]                 color_out
);
  localparam int IT = 12 + FRACT_RES;
  localparam int CW = $clog2(IT + 1);
  localparam logic signed [63:0] MAXV = (64'sd1 <<< (SLOPE_RES - 1)) - 64'sd1;

  typedef enum logic [3:0] {IDLE, SORT0, SORT1, SORT2, DIV_AB, DIV_AC, DIV_BC, SPLIT, ORIENT, COMMIT} state_t;
  state_t state_q, state_d;

  logic signed [11:0] vx_q [3], vy_q [3], vx_d [3], vy_d [3];
  logic [23:0] col_q;
  logic [IT-1:0] quo_q, quo_d;
  logic [11:0] rem_q, rem_d, den_q, den_d, adx, ody;
  logic neg_q, neg_d, dz_q, dz_d, bl_q;
  logic [CW-1:0] cnt_q;
  logic signed [SLOPE_RES-1:0] sab_q, sac_q, sbc_q, xs_q, slope, xb_fp;
  logic accept, div, last, load, ge;
  logic [1:0] lo, pa, pb;
  logic [12:0] sh;
  logic signed [12:0] odx, dyab;
  logic signed [63:0] mag, prod, split_x;

  function automatic logic signed [SLOPE_RES-1:0] sat(input logic signed [63:0] v);
    return (v > MAXV) ? SLOPE_RES'(MAXV) : (v < -MAXV) ? SLOPE_RES'(-MAXV) : SLOPE_RES'(v);
  endfunction

  function automatic logic signed [SLOPE_RES-1:0] fp(input logic signed [11:0] v);
    return SLOPE_RES'(v) <<< FRACT_RES;
  endfunction

  assign in_ready = state_q == IDLE;
  assign busy     = state_q != IDLE;
  assign accept   = in_valid && in_ready;
  assign div      = state_q inside {DIV_AB, DIV_AC, DIV_BC};
  assign last     = cnt_q == CW'(IT);
  assign lo       = (state_q == SORT1) ? 2'd1 : 2'd0;
  // Operands for the next division are loaded one cycle early (SORT2 or the previous sat cycle)
  assign load     = state_q == SORT2 || ((state_q == DIV_AB || state_q == DIV_AC) && last);
  assign pa       = (state_q == DIV_AC) ? 2'd1 : 2'd0;
  assign pb       = (state_q == SORT2) ? 2'd1 : 2'd2;
  assign odx      = 13'(vx_d[pb]) - 13'(vx_d[pa]);
  assign ody      = 12'(13'(vy_d[pb]) - 13'(vy_d[pa]));
  assign adx      = 12'((odx < 0) ? -odx : odx);
  assign sh       = {rem_q, quo_q[IT-1]};
  assign ge       = sh >= {1'b0, den_q};
  assign mag      = 64'(quo_q);
  assign slope    = dz_q ? '0 : sat(neg_q ? -mag : mag);
  assign dyab     = 13'(vy_q[1]) - 13'(vy_q[0]);
  assign prod     = 64'(sac_q) * 64'(dyab);
  assign split_x  = 64'(sat(prod)) + (64'(vx_q[0]) <<< FRACT_RES);
  assign xb_fp    = fp(vx_q[1]);

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = accept ? SORT0 : IDLE;
    else if (state_q == COMMIT) state_d = IDLE;
    else if (!div || last) state_d = state_t'(state_q + 4'd1);
  end

  always_comb begin
    vx_d = vx_q;
    vy_d = vy_q;
    if (accept) begin
      vx_d = '{x0, x1, x2};
      vy_d = '{y0, y1, y2};
    end else if (state_q inside {SORT0, SORT1, SORT2} && vy_q[lo] > vy_q[lo+2'd1]) begin
      vx_d[lo] = vx_q[lo+2'd1];
      vx_d[lo+2'd1] = vx_q[lo];
      vy_d[lo] = vy_q[lo+2'd1];
      vy_d[lo+2'd1] = vy_q[lo];
    end
  end

  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    den_d = den_q;
    neg_d = neg_q;
    dz_d  = dz_q;
    if (load) begin
      quo_d = {adx, {FRACT_RES{1'b0}}};
      rem_d = '0;
      den_d = ody;
      neg_d = odx < 0;
      dz_d  = ody == '0;
    end else if (div && !last) begin
      quo_d = {quo_q[IT-2:0], ge};
      rem_d = ge ? 12'(sh - {1'b0, den_q}) : sh[11:0];
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vx_q    <= '{default: '0};
      vy_q    <= '{default: '0};
      col_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      den_q   <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      sab_q   <= '0;
      sac_q   <= '0;
      sbc_q   <= '0;
      xs_q    <= '0;
      bl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (div && !last) ? cnt_q + 1'b1 : '0;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      if (accept) col_q <= color;
      if (state_q == DIV_AB && last) sab_q <= slope;
      if (state_q == DIV_AC && last) sac_q <= slope;
      if (state_q == DIV_BC && last) sbc_q <= slope;
      if (state_q == SPLIT) xs_q <= sat(split_x);
      if (state_q == ORIENT) bl_q <= 64'(xb_fp) <= 64'(xs_q);
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      fb_x_p1    <= '0;
      fb_y_p1    <= '0;
      fb_x_p2    <= '0;
      fb_y_p2    <= '0;
      fb_x_p3    <= '0;
      fb_y_p3    <= '0;
      fb_dx_p1p2 <= '0;
      fb_dx_p1p3 <= '0;
      ft_x_p1    <= '0;
      ft_y_p1    <= '0;
      ft_x_p2    <= '0;
      ft_y_p2    <= '0;
      ft_x_p3    <= '0;
      ft_y_p3    <= '0;
      ft_dx_p1p2 <= '0;
      ft_dx_p1p3 <= '0;
      color_out  <= '0;
    end else begin
      out_valid <= state_q == COMMIT;
      if (state_q == COMMIT) begin
        fb_x_p1    <= fp(vx_q[0]);
        fb_y_p1    <= fp(vy_q[0]);
        fb_x_p2    <= bl_q ? xb_fp : xs_q;
        fb_y_p2    <= fp(vy_q[1]);
        fb_x_p3    <= bl_q ? xs_q : xb_fp;
        fb_y_p3    <= fp(vy_q[1]);
        fb_dx_p1p2 <= bl_q ? sab_q : sac_q;
        fb_dx_p1p3 <= bl_q ? sac_q : sab_q;
        ft_x_p1    <= fp(vx_q[2]);
        ft_y_p1    <= fp(vy_q[2]);
        ft_x_p2    <= bl_q ? xb_fp : xs_q;
        ft_y_p2    <= fp(vy_q[1]);
        ft_x_p3    <= bl_q ? xs_q : xb_fp;
        ft_y_p3    <= fp(vy_q[1]);
        ft_dx_p1p2 <= bl_q ? sbc_q : sac_q;
        ft_dx_p1p3 <= bl_q ? sac_q : sbc_q;
        color_out  <= col_q;
      end
    end
  end
endmodule

// File: doc/triangle_setup.md
Name: triangle_setup

Overview:
- Triangle setup engine. Feeds the flat-top and flat-bottom scanline rasterizers.
- Accepts three integer screen-space vertices through a valid/ready handshake.
- Sorts the vertices by y, splits the triangle at the middle vertex, and computes per-scanline edge slopes with a serial divider.
- Presents both rasterizers' vertex/slope sets in SLOPE_RES-bit signed fixed point (FRACT_RES fraction bits). The rasterizers latch these outputs on fsync.

Parameters:
- SLOPE_RES, 28, total bits of every fixed-point output.
- FRACT_RES, 16, fraction bits of every fixed-point output.

Ports:
- pixel_clk  in  1  pixel clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  vertex set valid.
- in_ready  out  1  engine idle; a set is accepted on in_valid && in_ready.
- x0, y0, x1, y1, x2, y2  in  12 each, signed  vertex coordinates in integer pixels.
- color  in  24  triangle RGB; captured on accept.
- busy  out  1  high from the accept edge until the commit cycle, inclusive.
- out_valid  out  1  one-cycle pulse on the commit cycle.
- fb_x_p1, fb_y_p1, fb_x_p2, fb_y_p2, fb_x_p3, fb_y_p3  out  SLOPE_RES each, signed  flat-bottom vertices: p1 = apex, p2 = left base, p3 = right base.
- fb_dx_p1p2, fb_dx_p1p3  out  SLOPE_RES each, signed  flat-bottom left/right edge dx per scanline.
- ft_x_p1, ft_y_p1, ft_x_p2, ft_y_p2, ft_x_p3, ft_y_p3  out  SLOPE_RES each, signed  flat-top vertices: p1 = bottom apex, p2 = left top, p3 = right top.
- ft_dx_p1p2, ft_dx_p1p3  out  SLOPE_RES each, signed  flat-top left/right edge dx per scanline.
- color_out  out  24  committed color.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; busy = 0, out_valid = 0.
  - All fb_*, ft_* outputs and color_out = 0; in_ready = 1 once rst_n is high.
  - Reset mid-operation abandons the set: no out_valid, outputs stay 0.
- State sequence: IDLE -> SORT0 -> SORT1 -> SORT2 -> DIV_AB -> DIV_AC -> DIV_BC -> SPLIT -> ORIENT -> COMMIT -> IDLE.
- in_ready = 1 only in IDLE. in_valid is ignored in all other states.
- SORT0..SORT2: stable compare-swap on y over pairs (v0,v1), (v1,v2), (v0,v1). Equal y keeps input order. Result is A (top), B (middle), C (bottom), with yA <= yB <= yC.
- Each DIV state takes exactly FRACT_RES+13 cycles:
  - 12+FRACT_RES restoring-divider iterations, then 1 sign/saturate cycle.
  - Dividend is |dx| << FRACT_RES; divisor is dy >= 0.
  - Quotient truncates toward zero, then takes the sign of dx.
  - Result saturates to ±(2^(SLOPE_RES-1)-1).
  - dy = 0 forces the slope to 0. The cycle count is unchanged.
  - sAB = (xB-xA)/(yB-yA), sAC = (xC-xA)/(yC-yA), sBC = (xC-xB)/(yC-yB).
- SPLIT: xS = (xA<<FRACT_RES) + sAC*(yB-yA). The signed product and the sum saturate to SLOPE_RES bits. yS = yB.
- ORIENT: if (xB<<FRACT_RES) <= xS, B is left (tie goes to B-left); otherwise the split point is left.
- COMMIT: all outputs update in this single cycle, out_valid = 1, then the state returns to IDLE. Outputs hold until the next COMMIT or reset.
  - All y outputs are y<<FRACT_RES; vertex x outputs are x<<FRACT_RES, except xS, which is already fixed point.
  - fb: p1 = A; p2/p3 = left/right of {B, S}; dx_p1p2/dx_p1p3 = slope of the left/right edge. The B-side edge uses sAB; the S-side edge uses sAC.
  - ft: p1 = C; p2/p3 = left/right of {B, S}; the B-side edge uses sBC; the S-side edge uses sAC.
- Latency: out_valid is high exactly 3*(FRACT_RES+13)+6 cycles after the accept edge (93 at the defaults). Latency is fixed regardless of data.
- Degenerate inputs:
  - yA = yB gives an empty flat-bottom (fb y values equal).
  - yB = yC gives an empty flat-top.
  - All y equal gives all slopes 0.
  - All still complete normally.

Test Plan:
- Accept (50,60), (150,110), (100,10) -> out_valid exactly at cycle 93.
  - fb: p1 = (100,10), p2 = (50,60), p3 = (125,60), dx = -65536 / 32768.
  - ft: p1 = (150,110), dx = 131072 / 32768. All coordinates are <<16.
- (100,10), (200,60), (50,110) -> xS = 75<<16, S left.
  - fb: dx = -32768 / 131072.
  - ft: p2 = (75,60), p3 = (200,60), dx = -32768 / -196608.
- Flat-top input (10,20), (90,20), (50,100):
  - Stable sort gives A = (10,20), B = (90,20).
  - ft: p2 = (10,20), p3 = (90,20), dx = 32768 / -32768.
  - fb y values all 20<<16; fb dx pair = 32768 / 0.
- (0,0), (2,1), (-1,3) -> sAC = -21845 (truncated toward zero), xS = -21845, B right.
  - fb dx = -21845 / 131072; ft dx = -21845 / -98304.
- Handshake: hold in_valid high with two sets.
  - in_ready stays low while busy; out_valid is a single-cycle pulse.
  - The second set is accepted the cycle after COMMIT; outputs hold the first result until the second COMMIT.
- Assert rst_n low 40 cycles after accept -> outputs and color_out read 0 immediately.
  - No out_valid; in_ready = 1 after release; the next set completes at normal latency.
